// File: rtl/addsub_rr_scheduler.sv
// ---------------------------------------------------------------------------
// addsub_rr_scheduler
//   Time-shares one external combinational WIDTH-bit adder/subtractor between
//   NREQ requesters. Requesters are granted round-robin. Only one operation
//   is in flight at a time. The scheduler drives the shared datapath operands,
//   registers the datapath result, and returns it to the owning requester
//   over a valid/ready response channel.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_req_valid    [NREQ]        per-requester operation valid
//   o_req_ready    [NREQ]        per-requester accept, at most one bit high
//   i_req_a        [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   i_req_b        [NREQ*WIDTH]  operand B, same packing
//   i_req_op       [NREQ]        0 = A+B, 1 = A-B
//   o_resp_valid   [NREQ]        result valid, one-hot to the owner
//   i_resp_ready   [NREQ]        per-requester result accept
//   o_resp_sum     [WIDTH]       registered result
//   o_resp_carry                 registered carry-out
//   o_dp_a         [WIDTH]       shared datapath operand a
//   o_dp_b         [WIDTH]       shared datapath operand b (datapath applies b^en)
//   o_dp_en                      shared datapath subtract enable
//   i_dp_sum       [WIDTH]       shared datapath sum
//   i_dp_carry                   shared datapath carry
// ---------------------------------------------------------------------------
module addsub_rr_scheduler #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NREQ-1:0]         i_req_valid,
    output logic [NREQ-1:0]         o_req_ready,
    input  logic [NREQ*WIDTH-1:0]   i_req_a,
    input  logic [NREQ*WIDTH-1:0]   i_req_b,
    input  logic [NREQ-1:0]         i_req_op,
    output logic [NREQ-1:0]         o_resp_valid,
    input  logic [NREQ-1:0]         i_resp_ready,
    output logic [WIDTH-1:0]        o_resp_sum,
    output logic                    o_resp_carry,
    output logic [WIDTH-1:0]        o_dp_a,
    output logic [WIDTH-1:0]        o_dp_b,
    output logic                    o_dp_en,
    input  logic [WIDTH-1:0]        i_dp_sum,
    input  logic                    i_dp_carry
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTRW-1:0]     r_ptr;
    logic [PTRW-1:0]     r_owner;
    logic [NREQ-1:0]     r_resp_valid;
    logic [WIDTH-1:0]    r_resp_sum;
    logic                r_resp_carry;
    logic [WIDTH-1:0]    r_dp_a;
    logic [WIDTH-1:0]    r_dp_b;
    logic                r_dp_en;

    logic                w_found;
    logic [PTRW-1:0]     w_grant_idx;
    logic [NREQ-1:0]     w_req_ready;
    logic [WIDTH-1:0]    w_sel_a;
    logic [WIDTH-1:0]    w_sel_b;
    logic                w_sel_op;

    // (p + k) mod NREQ for p < NREQ and 1 <= k <= NREQ; one subtraction suffices.
    function automatic logic [PTRW-1:0] wrap_idx(input logic [PTRW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) begin
            s = s - NREQ;
        end else begin
            s = s;
        end
        return PTRW'(s);
    endfunction

    // Round-robin search: first valid requester after the last winner.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && i_req_valid[wrap_idx(r_ptr, k)]) begin
                w_found     = 1'b1;
                w_grant_idx = wrap_idx(r_ptr, k);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Operand mux for the candidate winner.
    always_comb begin
        w_sel_a  = i_req_a[w_grant_idx*WIDTH +: WIDTH];
        w_sel_b  = i_req_b[w_grant_idx*WIDTH +: WIDTH];
        w_sel_op = i_req_op[w_grant_idx];
    end

    // Next-state and combinational accept; accept is suppressed while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && i_rst_n) begin
                    w_req_ready[w_grant_idx] = 1'b1;
                    w_state_nxt              = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (i_resp_ready[r_owner]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer, datapath operand and response registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= PTRW'(NREQ - 1);
            r_owner      <= '0;
            r_resp_valid <= '0;
            r_resp_sum   <= '0;
            r_resp_carry <= 1'b0;
            r_dp_a       <= '0;
            r_dp_b       <= '0;
            r_dp_en      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_dp_a  <= w_sel_a;
                        r_dp_b  <= w_sel_b;
                        r_dp_en <= w_sel_op;
                        r_owner <= w_grant_idx;
                        r_ptr   <= w_grant_idx;
                    end else begin
                        r_ptr <= r_ptr;
                    end
                end
                ST_EXEC: begin
                    r_resp_sum   <= i_dp_sum;
                    r_resp_carry <= i_dp_carry;
                    r_resp_valid <= NREQ'(1'b1) << r_owner;
                end
                ST_RESP: begin
                    if (i_resp_ready[r_owner]) begin
                        r_resp_valid <= '0;
                    end else begin
                        r_resp_valid <= r_resp_valid;
                    end
                end
                default: begin
                    r_resp_valid <= '0;
                end
            endcase
        end
    end

    assign o_req_ready  = w_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_sum   = r_resp_sum;
    assign o_resp_carry = r_resp_carry;
    assign o_dp_a       = r_dp_a;
    assign o_dp_b       = r_dp_b;
    assign o_dp_en      = r_dp_en;

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_addsub_rr_scheduler
//   Directed bench for addsub_rr_scheduler (NREQ=2, WIDTH=4). Contains a
//   behavioural model of the shared adder/subtractor that is wired to the
//   scheduler's datapath ports.
// ---------------------------------------------------------------------------
module tb_addsub_rr_scheduler;

    localparam int NREQ  = 2;
    localparam int WIDTH = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [7:0]         req_a;
    logic [7:0]         req_b;
    logic [NREQ-1:0]    req_op;
    logic [NREQ-1:0]    resp_valid;
    logic [NREQ-1:0]    resp_ready;
    logic [3:0]         resp_sum;
    logic               resp_carry;
    logic [3:0]         dp_a;
    logic [3:0]         dp_b;
    logic               dp_en;
    logic [3:0]         dp_sum;
    logic               dp_carry;

    int checks;
    int failures;

    addsub_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_op     (req_op),
        .o_resp_valid (resp_valid),
        .i_resp_ready (resp_ready),
        .o_resp_sum   (resp_sum),
        .o_resp_carry (resp_carry),
        .o_dp_a       (dp_a),
        .o_dp_b       (dp_b),
        .o_dp_en      (dp_en),
        .i_dp_sum     (dp_sum),
        .i_dp_carry   (dp_carry)
    );

    // Shared adder/subtractor: a + (b ^ en) + en.
    always_comb begin
        {dp_carry, dp_sum} = {1'b0, dp_a} + {1'b0, dp_b ^ {4{dp_en}}} + {4'd0, dp_en};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic [1:0] v, input logic [3:0] s, input logic c);
        check({tag, "_valid"}, {30'd0, resp_valid}, {30'd0, v});
        check({tag, "_sum"},   {28'd0, resp_sum},   {28'd0, s});
        check({tag, "_carry"}, {31'd0, resp_carry}, {31'd0, c});
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        req_a      = 8'h00;
        req_b      = 8'h00;
        req_op     = 2'b00;
        resp_ready = 2'b00;
        tick();
        tick();
        rst_n = 1'b1;

        // 1. Idle after reset.
        for (int i = 0; i < 5; i++) begin
            check("idle_ready", {30'd0, req_ready}, 32'd0);
            check_resp("idle_resp", 2'b00, 4'd0, 1'b0);
            check("idle_dp", {23'd0, dp_a, dp_b, dp_en}, 32'd0);
            tick();
        end

        // 2. Requester 0 add 5+3.
        req_a     = 8'h05;
        req_b     = 8'h03;
        req_op    = 2'b00;
        req_valid = 2'b01;
        #1;
        check("add_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        check("add_ready_drop", {30'd0, req_ready}, 32'd0);
        check("add_dp", {23'd0, dp_a, dp_b, dp_en}, {23'd0, 4'd5, 4'd3, 1'b0});
        check("add_exec_valid", {30'd0, resp_valid}, 32'd0);
        tick();
        check_resp("add_resp", 2'b01, 4'd8, 1'b0);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        check("add_done", {30'd0, resp_valid}, 32'd0);

        // 3. Requester 1 subtract 3-5, then 9-9.
        req_a     = 8'h30;
        req_b     = 8'h50;
        req_op    = 2'b10;
        req_valid = 2'b10;
        #1;
        check("sub1_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        check("sub1_dp", {23'd0, dp_a, dp_b, dp_en}, {23'd0, 4'd3, 4'd5, 1'b1});
        tick();
        check_resp("sub1_resp", 2'b10, 4'hE, 1'b0);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        req_a     = 8'h90;
        req_b     = 8'h90;
        req_valid = 2'b10;
        #1;
        check("sub2_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        check_resp("sub2_resp", 2'b10, 4'h0, 1'b1);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;

        // 4. Reset, then both valid: grant order 0,1,0,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_a      = 8'h71;
        req_b      = 8'h92;
        req_op     = 2'b00;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                check("rr_ready0", {30'd0, req_ready}, 32'd1);
                tick();
                tick();
                check_resp("rr_resp0", 2'b01, 4'd3, 1'b0);
            end else begin
                check("rr_ready1", {30'd0, req_ready}, 32'd2);
                tick();
                tick();
                check_resp("rr_resp1", 2'b10, 4'd0, 1'b1);
            end
            tick();
        end

        // 5. Backpressure on requester 0; requester 1 stays valid.
        resp_ready = 2'b00;
        #1;
        check("bp_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b10;
        tick();
        check_resp("bp_first", 2'b01, 4'd3, 1'b0);
        resp_ready = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_resp("bp_hold", 2'b01, 4'd3, 1'b0);
            check("bp_no_grant", {30'd0, req_ready}, 32'd0);
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        check("bp_release", {30'd0, resp_valid}, 32'd0);
        check("bp_next_grant", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        tick();
        check_resp("bp_r1_resp", 2'b10, 4'd0, 1'b1);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;

        // 6. Reset during EXEC: operation discarded, pointer restored.
        req_a     = 8'h24;
        req_b     = 8'h11;
        req_valid = 2'b01;
        #1;
        check("rst_grant", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        check("rst_exec_dp", {23'd0, dp_a, dp_b, dp_en}, {23'd0, 4'd4, 4'd1, 1'b0});
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_ready_low", {30'd0, req_ready}, 32'd0);
        tick();
        rst_n     = 1'b1;
        req_valid = 2'b00;
        check_resp("rst_resp", 2'b00, 4'd0, 1'b0);
        check("rst_dp", {23'd0, dp_a, dp_b, dp_en}, 32'd0);
        tick();
        tick();
        check("rst_no_resp", {30'd0, resp_valid}, 32'd0);
        req_valid = 2'b11;
        #1;
        check("rst_next_grant", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        check_resp("rst_after_resp", 2'b01, 4'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
